// File: rtl/alu_multiciclo_if.sv
// ---------------------------------------------------------------------------
// alu_multiciclo_if
//   Request/response bundle between a client and the multi-cycle ALU.
//   Ports (as seen from the ALU, slave modport):
//     start   in   1          request, accepted only while busy is low
//     sel     in   2          00 add, 01 sub, 10 mul, 11 reserved
//     A, B    in   WIDTH      operands, latched when the request is accepted
//     c       in   1          carry-in (add) / borrow-in (sub)
//     busy    out  1          high whenever the ALU is not idle
//     done    out  1          one-cycle pulse, ALU_out/flag valid
//     ALU_out out  2*WIDTH    result, held until the next operation
//     flag    out  1          carry / borrow / upper-half-nonzero
// ---------------------------------------------------------------------------
interface alu_multiciclo_if #(
  parameter int WIDTH = 8
) ();

  logic                 start;
  logic [1:0]           sel;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic                 c;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   ALU_out;
  logic                 flag;

  modport master (
    output start, sel, A, B, c,
    input  busy, done, ALU_out, flag
  );

  modport slave (
    input  start, sel, A, B, c,
    output busy, done, ALU_out, flag
  );

endinterface

// File: rtl/alu_multiciclo.sv
// ---------------------------------------------------------------------------
// alu_multiciclo
//   Registered ALU with a start/busy/done handshake. Add and subtract finish
//   one cycle after the request is accepted; multiply is an LSB-first
//   shift-add over WIDTH cycles followed by the DONE cycle.
//   Ports:
//     clk   in   rising-edge clock
//     rst   in   asynchronous, active-high reset (aborts any operation)
//     bus   slave side of alu_multiciclo_if (start/sel/A/B/c in,
//           busy/done/ALU_out/flag out)
// ---------------------------------------------------------------------------
module alu_multiciclo #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  alu_multiciclo_if.slave   bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] SEL_ADD = 2'b00;
  localparam logic [1:0] SEL_SUB = 2'b01;
  localparam logic [1:0] SEL_MUL = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t               state_q, state_d;

  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   alu_out_q, alu_out_d;
  logic                 flag_q, flag_d;
  logic                 busy_q;
  logic                 done_q;

  // One extra bit on add/sub exposes the carry/borrow directly.
  logic [WIDTH:0]       sum_s;
  logic [WIDTH:0]       diff_s;
  logic [2*WIDTH-1:0]   a_ext_s;
  logic [2*WIDTH-1:0]   partial_s;
  logic [2*WIDTH-1:0]   mul_next_s;

  // Arithmetic on the live bus operands (used only in the accepting cycle).
  always_comb begin
    sum_s  = {1'b0, bus.A} + {1'b0, bus.B} + {{WIDTH{1'b0}}, bus.c};
    // A - B - c as a (WIDTH+1)-bit value: bit WIDTH is set exactly when A < B + c.
    diff_s = {1'b0, bus.A} - {1'b0, bus.B} - {{WIDTH{1'b0}}, bus.c};
  end

  // Shift-add step: the accumulator value after folding in multiplier bit cnt.
  always_comb begin
    a_ext_s = {{WIDTH{1'b0}}, a_q};
    if (b_q[cnt_q]) begin
      partial_s = a_ext_s << cnt_q;
    end else begin
      partial_s = {2*WIDTH{1'b0}};
    end
    mul_next_s = acc_q + partial_s;
  end

  // State register plus registered busy/done decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE);
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.sel == SEL_MUL) begin
            state_d = ST_MUL;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_MUL;
        end
      end
      ST_DONE: begin
        // Start is deliberately ignored here; a new op waits for IDLE.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath next values: operand latches, accumulator, counter and result.
  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    alu_out_d = alu_out_q;
    flag_d    = flag_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          case (bus.sel)
            SEL_ADD: begin
              alu_out_d = {{WIDTH{1'b0}}, sum_s[WIDTH-1:0]};
              flag_d    = sum_s[WIDTH];
            end
            SEL_SUB: begin
              alu_out_d = {{WIDTH{1'b0}}, diff_s[WIDTH-1:0]};
              flag_d    = diff_s[WIDTH];
            end
            SEL_MUL: begin
              a_d   = bus.A;
              b_d   = bus.B;
              acc_d = {2*WIDTH{1'b0}};
              cnt_d = {CNT_W{1'b0}};
            end
            default: begin
              alu_out_d = {2*WIDTH{1'b0}};
              flag_d    = 1'b0;
            end
          endcase
        end else begin
          alu_out_d = alu_out_q;
        end
      end
      ST_MUL: begin
        acc_d = mul_next_s;
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          alu_out_d = mul_next_s;
          flag_d    = |mul_next_s[2*WIDTH-1:WIDTH];
        end else begin
          flag_d = flag_q;
        end
      end
      ST_DONE: begin
        alu_out_d = alu_out_q;
      end
      default: begin
        alu_out_d = alu_out_q;
      end
    endcase
  end

  // Datapath registers; result and flag persist until overwritten or reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= {WIDTH{1'b0}};
      b_q       <= {WIDTH{1'b0}};
      acc_q     <= {2*WIDTH{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      alu_out_q <= {2*WIDTH{1'b0}};
      flag_q    <= 1'b0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      alu_out_q <= alu_out_d;
      flag_q    <= flag_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.ALU_out = alu_out_q;
  assign bus.flag    = flag_q;

endmodule

// File: tb/tb_alu_multiciclo.sv
// ---------------------------------------------------------------------------
// tb_alu_multiciclo
//   Directed bench for alu_multiciclo: an 8-bit and a 16-bit instance share
//   clock and reset. A vector table covers the arithmetic; hand-written
//   sequences cover start-while-busy and reset during a multiply.
// ---------------------------------------------------------------------------
module tb_alu_multiciclo;

  logic clk;
  logic rst;

  alu_multiciclo_if #(.WIDTH(8))  if8  ();
  alu_multiciclo_if #(.WIDTH(16)) if16 ();

  alu_multiciclo #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));
  alu_multiciclo #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wide;
    logic [1:0]  sel;
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    logic [31:0] exp_out;
    logic        exp_flag;
    int          exp_lat;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  int total;
  int passed;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sample(input logic wide, output logic [31:0] o, output logic f,
                        output logic d, output logic bz);
    if (wide) begin
      o = 32'(if16.ALU_out); f = if16.flag; d = if16.done; bz = if16.busy;
    end else begin
      o = 32'(if8.ALU_out);  f = if8.flag;  d = if8.done;  bz = if8.busy;
    end
  endtask

  task automatic drive(input logic wide, input logic st, input logic [1:0] sel,
                       input logic [15:0] a, input logic [15:0] b, input logic c);
    if (wide) begin
      if16.start = st; if16.sel = sel; if16.A = a; if16.B = b; if16.c = c;
    end else begin
      if8.start = st; if8.sel = sel; if8.A = a[7:0]; if8.B = b[7:0]; if8.c = c;
    end
  endtask

  // Issue one op; returns result, flag, cycles from accept edge to done, and
  // whether the ALU is idle with done low one cycle after the done pulse.
  task automatic run_op(input logic wide, input logic [1:0] sel, input logic [15:0] a,
                        input logic [15:0] b, input logic c,
                        output logic [31:0] o, output logic f, output int lat,
                        output logic idle_after);
    logic d, bz;
    @(posedge clk); #1;
    drive(wide, 1'b1, sel, a, b, c);
    @(posedge clk); #1;
    drive(wide, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0);
    lat = 1;
    sample(wide, o, f, d, bz);
    while (!d && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      sample(wide, o, f, d, bz);
    end
    @(posedge clk); #1;
    begin
      logic [31:0] o2; logic f2;
      sample(wide, o2, f2, d, bz);
    end
    idle_after = !d && !bz;
  endtask

  initial begin
    logic [31:0] o;
    logic        f, d, bz, idle;
    int          lat;
    int          done_cnt;
    logic [31:0] got_out;
    logic        got_flag;

    total  = 0;
    passed = 0;

    //            wide  sel    a         b         c     out           flag  lat
    vecs[0]  = '{1'b0, 2'b00, 16'd200,  16'd100,  1'b0, 32'h0000_002C, 1'b1, 1};
    vecs[1]  = '{1'b0, 2'b00, 16'd1,    16'd1,    1'b1, 32'h0000_0003, 1'b0, 1};
    vecs[2]  = '{1'b0, 2'b00, 16'd255,  16'd0,    1'b1, 32'h0000_0000, 1'b1, 1};
    vecs[3]  = '{1'b0, 2'b01, 16'd5,    16'd9,    1'b0, 32'h0000_00FC, 1'b1, 1};
    vecs[4]  = '{1'b0, 2'b01, 16'd9,    16'd5,    1'b1, 32'h0000_0003, 1'b0, 1};
    vecs[5]  = '{1'b0, 2'b01, 16'd5,    16'd4,    1'b1, 32'h0000_0000, 1'b0, 1};
    vecs[6]  = '{1'b0, 2'b10, 16'd255,  16'd255,  1'b0, 32'h0000_FE01, 1'b1, 9};
    vecs[7]  = '{1'b0, 2'b11, 16'd9,    16'd7,    1'b1, 32'h0000_0000, 1'b0, 1};
    vecs[8]  = '{1'b0, 2'b10, 16'd15,   16'd3,    1'b1, 32'h0000_002D, 1'b0, 9};
    vecs[9]  = '{1'b0, 2'b10, 16'd0,    16'd200,  1'b0, 32'h0000_0000, 1'b0, 9};
    vecs[10] = '{1'b0, 2'b10, 16'd128,  16'd2,    1'b0, 32'h0000_0100, 1'b1, 9};
    vecs[11] = '{1'b0, 2'b10, 16'd16,   16'd15,   1'b0, 32'h0000_00F0, 1'b0, 9};
    vecs[12] = '{1'b1, 2'b10, 16'hFFFF, 16'h0002, 1'b0, 32'h0001_FFFE, 1'b1, 17};
    vecs[13] = '{1'b1, 2'b11, 16'h1234, 16'h5678, 1'b1, 32'h0000_0000, 1'b0, 1};

    rst = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0);
    drive(1'b1, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0);
    #12 rst = 1'b0;
    #1;
    for (int w = 0; w < 2; w++) begin
      sample(w[0], o, f, d, bz);
      check($sformatf("reset_out_w%0d", w),  o,         32'h0);
      check($sformatf("reset_flag_w%0d", w), 32'(f),    32'h0);
      check($sformatf("reset_done_w%0d", w), 32'(d),    32'h0);
      check($sformatf("reset_busy_w%0d", w), 32'(bz),   32'h0);
    end

    for (int i = 0; i < NVEC; i++) begin
      run_op(vecs[i].wide, vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].c, o, f, lat, idle);
      check($sformatf("v%0d_out", i),  o,           vecs[i].exp_out);
      check($sformatf("v%0d_flag", i), 32'(f),      32'(vecs[i].exp_flag));
      check($sformatf("v%0d_lat", i),  32'(lat),    32'(vecs[i].exp_lat));
      check($sformatf("v%0d_idle", i), 32'(idle),   32'h1);
    end

    // Start pulsed with new operands during MUL must not disturb 7*6.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 2'b10, 16'd7, 16'd6, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 2'b10, 16'd7, 16'd6, 1'b0);
    done_cnt = 0;
    got_out  = 32'h0;
    got_flag = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      sample(1'b0, o, f, d, bz);
      if (d) begin
        done_cnt++;
        got_out  = o;
        got_flag = f;
      end
      if (k == 3) drive(1'b0, 1'b1, 2'b00, 16'd1, 16'd1, 1'b1);
      if (k == 5) drive(1'b0, 1'b0, 2'b00, 16'd0, 16'd0, 1'b0);
      @(posedge clk); #1;
    end
    check("busy_ignore_done_count", 32'(done_cnt), 32'd1);
    check("busy_ignore_out",        got_out,       32'd42);
    check("busy_ignore_flag",       32'(got_flag), 32'h0);

    // Asynchronous reset in the middle of MUL cycle 4.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 2'b10, 16'd255, 16'd255, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 2'b00, 16'd0, 16'd0, 1'b0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    sample(1'b0, o, f, d, bz);
    check("rst_mid_busy", 32'(bz), 32'h0);
    check("rst_mid_done", 32'(d),  32'h0);
    check("rst_mid_out",  o,       32'h0);
    #2 rst = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      sample(1'b0, o, f, d, bz);
      if (d) done_cnt++;
    end
    check("rst_no_done", 32'(done_cnt), 32'd0);
    run_op(1'b0, 2'b00, 16'd2, 16'd3, 1'b0, o, f, lat, idle);
    check("after_rst_add_out", o,         32'd5);
    check("after_rst_add_lat", 32'(lat),  32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
